// File: rtl/riscv_amo_seq.sv
// rtl/riscv_amo_seq.sv - RISC-V A-extension AMO read-modify-write sequencer
// Drives a locked read, one compute cycle and a locked write on the dmem port, then returns the old value.
module riscv_amo_seq #(
   parameter int XLEN = 32
) (
   input  logic            clk_i,
   input  logic            rst_ni,
   input  logic            req_i,
   input  logic [4:0]      funct5_i,
   input  logic            dw_i,
   input  logic [XLEN-1:0] adr_i,
   input  logic [XLEN-1:0] opB_i,
   output logic            busy_o,
   output logic            done_o,
   output logic            err_o,
   output logic [XLEN-1:0] r_o,
   output logic            dmem_req_o,
   output logic            dmem_lock_o,
   output logic            dmem_we_o,
   output logic [2:0]      dmem_size_o,
   output logic [XLEN-1:0] dmem_adr_o,
   output logic [XLEN-1:0] dmem_d_o,
   input  logic            dmem_ack_i,
   input  logic [XLEN-1:0] dmem_q_i,
   input  logic            dmem_err_i
);

   localparam logic [4:0] AMO_SWAP = 5'b00001;
   localparam logic [4:0] AMO_ADD  = 5'b00000;
   localparam logic [4:0] AMO_XOR  = 5'b00100;
   localparam logic [4:0] AMO_AND  = 5'b01100;
   localparam logic [4:0] AMO_OR   = 5'b01000;
   localparam logic [4:0] AMO_MIN  = 5'b10000;
   localparam logic [4:0] AMO_MAX  = 5'b10100;
   localparam logic [4:0] AMO_MINU = 5'b11000;
   localparam logic [4:0] AMO_MAXU = 5'b11100;

   localparam logic [2:0] SIZE_WORD  = 3'b010;
   localparam logic [2:0] SIZE_DWORD = 3'b011;

   typedef enum logic [2:0] {IDLE, RD, CALC, WR, FIN} state_t;

   state_t          state, state_nxt;
   logic [4:0]      funct5, funct5_nxt;
   logic            dw, dw_nxt;
   logic [XLEN-1:0] opb, opb_nxt;
   logic [XLEN-1:0] old_val, old_nxt;

   logic            busy_nxt, done_nxt, err_nxt;
   logic [XLEN-1:0] r_nxt;
   logic            req_nxt, lock_nxt, we_nxt;
   logic [2:0]      size_nxt;
   logic [XLEN-1:0] adr_nxt, d_nxt;

   logic            funct5_ok, size_ok, align_ok, legal;
   logic [XLEN-1:0] opa_ext, opb_ext, amo_new;

   always_comb begin
      case (funct5_i)
         AMO_SWAP, AMO_ADD, AMO_XOR, AMO_AND, AMO_OR,
         AMO_MIN, AMO_MAX, AMO_MINU, AMO_MAXU: funct5_ok = 1'b1;
         default:                              funct5_ok = 1'b0;
      endcase
   end

   assign size_ok  = !dw_i || (XLEN == 64);
   assign align_ok = dw_i ? (adr_i[2:0] == 3'b000) : (adr_i[1:0] == 2'b00);
   assign legal    = funct5_ok && size_ok && align_ok;

   // Word ops sign-extend both operands: the low 32 result bits and both signed and unsigned orderings stay correct.
   assign opa_ext = dw ? old_val : XLEN'(signed'(old_val[31:0]));
   assign opb_ext = dw ? opb     : XLEN'(signed'(opb[31:0]));

   always_comb begin
      case (funct5)
         AMO_ADD:  amo_new = opa_ext + opb_ext;
         AMO_XOR:  amo_new = opa_ext ^ opb_ext;
         AMO_AND:  amo_new = opa_ext & opb_ext;
         AMO_OR:   amo_new = opa_ext | opb_ext;
         AMO_MIN:  amo_new = ($signed(opa_ext) <= $signed(opb_ext)) ? opa_ext : opb_ext;
         AMO_MAX:  amo_new = ($signed(opa_ext) >= $signed(opb_ext)) ? opa_ext : opb_ext;
         AMO_MINU: amo_new = (opa_ext <= opb_ext) ? opa_ext : opb_ext;
         AMO_MAXU: amo_new = (opa_ext >= opb_ext) ? opa_ext : opb_ext;
         default:  amo_new = opb_ext;
      endcase
   end

   always_comb begin
      state_nxt  = state;
      funct5_nxt = funct5;
      dw_nxt     = dw;
      opb_nxt    = opb;
      old_nxt    = old_val;
      busy_nxt   = busy_o;
      done_nxt   = 1'b0;
      err_nxt    = 1'b0;
      r_nxt      = r_o;
      req_nxt    = dmem_req_o;
      lock_nxt   = dmem_lock_o;
      we_nxt     = dmem_we_o;
      size_nxt   = dmem_size_o;
      adr_nxt    = dmem_adr_o;
      d_nxt      = dmem_d_o;

      case (state)
         IDLE: begin
            if (req_i) begin
               funct5_nxt = funct5_i;
               dw_nxt     = dw_i;
               opb_nxt    = opB_i;
               if (legal) begin
                  state_nxt = RD;
                  busy_nxt  = 1'b1;
                  req_nxt   = 1'b1;
                  lock_nxt  = 1'b1;
                  we_nxt    = 1'b0;
                  adr_nxt   = adr_i;
                  size_nxt  = dw_i ? SIZE_DWORD : SIZE_WORD;
               end else begin
                  state_nxt = FIN;
                  err_nxt   = 1'b1;
               end
            end
         end
         RD: begin
            if (dmem_err_i) begin
               state_nxt = FIN;
               req_nxt   = 1'b0;
               lock_nxt  = 1'b0;
               busy_nxt  = 1'b0;
               err_nxt   = 1'b1;
            end else if (dmem_ack_i) begin
               state_nxt = CALC;
               old_nxt   = dmem_q_i;
               req_nxt   = 1'b0;
            end
         end
         CALC: begin
            state_nxt = WR;
            d_nxt     = amo_new;
            req_nxt   = 1'b1;
            we_nxt    = 1'b1;
         end
         WR: begin
            if (dmem_err_i || dmem_ack_i) begin
               state_nxt = FIN;
               req_nxt   = 1'b0;
               we_nxt    = 1'b0;
               lock_nxt  = 1'b0;
               busy_nxt  = 1'b0;
               err_nxt   = dmem_err_i;
               done_nxt  = !dmem_err_i;
               if (!dmem_err_i) r_nxt = opa_ext;
            end
         end
         FIN: begin
            state_nxt = IDLE;
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state       <= IDLE;
         funct5      <= 5'b0;
         dw          <= 1'b0;
         opb         <= '0;
         old_val     <= '0;
         busy_o      <= 1'b0;
         done_o      <= 1'b0;
         err_o       <= 1'b0;
         r_o         <= '0;
         dmem_req_o  <= 1'b0;
         dmem_lock_o <= 1'b0;
         dmem_we_o   <= 1'b0;
         dmem_size_o <= 3'b0;
         dmem_adr_o  <= '0;
         dmem_d_o    <= '0;
      end else begin
         state       <= state_nxt;
         funct5      <= funct5_nxt;
         dw          <= dw_nxt;
         opb         <= opb_nxt;
         old_val     <= old_nxt;
         busy_o      <= busy_nxt;
         done_o      <= done_nxt;
         err_o       <= err_nxt;
         r_o         <= r_nxt;
         dmem_req_o  <= req_nxt;
         dmem_lock_o <= lock_nxt;
         dmem_we_o   <= we_nxt;
         dmem_size_o <= size_nxt;
         dmem_adr_o  <= adr_nxt;
         dmem_d_o    <= d_nxt;
      end
   end

endmodule
